fft_cmul_round_sat: RTL and testbench

- Downstream stage of the FFT twiddle multipliers (signed 18b data × unsigned 15b twiddle magnitude → signed 33b product).
- Takes the four partial products of one complex butterfly multiply plus twiddle sign flags and forms the complex result.
- Rounds, scales and saturates that result back to the 18b datapath width, under valid/ready flow control.
- Flags and counts saturation events for the host.

---
 rtl/fft_cmul_round_sat.sv | 139 +++++++++++++
 tb/tb_fft_cmul_round_sat.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cmul_round_sat.sv
// Purpose: combine four twiddle partial products into a complex sample, round, scale and saturate to OUT_W.
// Latency: 2 cycles from input transfer to m_valid (S1 sum, S2 round/saturate); 1 beat/cycle throughput.
// Backpressure: each stage advances when empty or draining; s_ready drops only when both stages are full and m_ready=0.
module fft_cmul_round_sat #(
  parameter int PROD_W = 33,
  parameter int SHIFT  = 15,
  parameter int OUT_W  = 18,
  parameter int CNT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PROD_W-1:0] s_p_rr,
  input  logic [PROD_W-1:0] s_p_ii,
  input  logic [PROD_W-1:0] s_p_ri,
  input  logic [PROD_W-1:0] s_p_ir,
  input  logic              s_neg_r,
  input  logic              s_neg_i,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_re,
  output logic [OUT_W-1:0]  m_im,
  output logic              m_last,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              ovf_clr
);

  // EW: summation width (one guard bit); RW: rounding-add width (one more guard bit)
  localparam int EW = PROD_W + 1;
  localparam int RW = PROD_W + 2;

  localparam logic signed [RW-1:0] HALF    = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] LIM_MAX = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] LIM_MIN = -LIM_MAX - RW'(1);
  localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                 v1;
  logic                 last1;
  logic signed [EW-1:0] re1, im1;
  logic                 adv1, adv2;

  logic signed [EW-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [EW-1:0] t_rr, t_ii, t_ri, t_ir;
  logic signed [EW-1:0] sum_re, sum_im;

  logic signed [RW-1:0] ext_re, ext_im, x_re, x_im, r_re, r_im;
  logic                 hi_re, lo_re, hi_im, lo_im, sat_any;
  logic [OUT_W-1:0]     q_re, q_im;

  assign adv2    = !m_valid || m_ready;
  assign adv1    = !v1 || adv2;
  assign s_ready = adv1;

  // S1 combinational: sign-extend, apply twiddle signs, form real/imag sums
  always_comb begin
    e_rr   = {s_p_rr[PROD_W-1], s_p_rr};
    e_ii   = {s_p_ii[PROD_W-1], s_p_ii};
    e_ri   = {s_p_ri[PROD_W-1], s_p_ri};
    e_ir   = {s_p_ir[PROD_W-1], s_p_ir};
    t_rr   = s_neg_r ? -e_rr : e_rr;
    t_ii   = s_neg_i ? -e_ii : e_ii;
    t_ri   = s_neg_i ? -e_ri : e_ri;
    t_ir   = s_neg_r ? -e_ir : e_ir;
    sum_re = t_rr - t_ii;
    sum_im = t_ri + t_ir;
  end

  // S1 register: valid always follows the input on advance, data only on a real beat
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      v1    <= 1'b0;
      re1   <= '0;
      im1   <= '0;
      last1 <= 1'b0;
    end else if (adv1) begin
      v1 <= s_valid;
      if (s_valid) begin
        re1   <= sum_re;
        im1   <= sum_im;
        last1 <= s_last;
      end
    end
  end

  // S2 combinational: round half toward +inf, arithmetic shift, clamp each component
  always_comb begin
    ext_re  = {re1[EW-1], re1};
    ext_im  = {im1[EW-1], im1};
    x_re    = ext_re + HALF;
    x_im    = ext_im + HALF;
    r_re    = x_re >>> SHIFT;
    r_im    = x_im >>> SHIFT;
    hi_re   = r_re > LIM_MAX;
    lo_re   = r_re < LIM_MIN;
    hi_im   = r_im > LIM_MAX;
    lo_im   = r_im < LIM_MIN;
    q_re    = hi_re ? OUT_MAX : (lo_re ? OUT_MIN : r_re[OUT_W-1:0]);
    q_im    = hi_im ? OUT_MAX : (lo_im ? OUT_MIN : r_im[OUT_W-1:0]);
    sat_any = hi_re || lo_re || hi_im || lo_im;
  end

  // S2 output register: holds steady while the downstream stalls
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_last  <= 1'b0;
    end else if (adv2) begin
      m_valid <= v1;
      if (v1) begin
        m_re   <= q_re;
        m_im   <= q_im;
        m_last <= last1;
      end
    end
  end

  // Saturation accounting on S2 load; a clear wins over a same-cycle event
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (adv2 && v1 && sat_any) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != {CNT_W{1'b1}}) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_cmul_round_sat.sv
// Bench for fft_cmul_round_sat: directed scenarios plus randomized streams scored
// against an integer-arithmetic reference model and an in-order expectation queue.
module tb_fft_cmul_round_sat;

  localparam int PW = 33;
  localparam int SH = 15;
  localparam int OW = 18;
  localparam int CW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_p_rr = '0, s_p_ii = '0, s_p_ri = '0, s_p_ir = '0;
  logic          s_neg_r = 1'b0, s_neg_i = 1'b0, s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_re, m_im;
  logic          m_last;
  logic          ovf_sticky;
  logic [CW-1:0] ovf_count;
  logic          ovf_clr = 1'b0;

  fft_cmul_round_sat #(.PROD_W(PW), .SHIFT(SH), .OUT_W(OW), .CNT_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_p_rr(s_p_rr), .s_p_ii(s_p_ii), .s_p_ri(s_p_ri), .s_p_ir(s_p_ir),
    .s_neg_r(s_neg_r), .s_neg_i(s_neg_i), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_re(m_re), .m_im(m_im), .m_last(m_last),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [OW-1:0] re;
    logic [OW-1:0] im;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t    exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      occ = 0;
  int      out_cnt = 0;
  bit      chk_lat = 1'b0;
  bit      bp_on = 1'b0;
  longint  exp_cnt = 0;
  bit      exp_sticky = 1'b0;
  bit      prev_stall = 1'b0;
  logic [2*OW+1:0] prev_out = '0;

  always @(posedge ap_clk) cyc++;

  // Reference: floor((x + 2^(SH-1)) / 2^SH), then clamp to the signed OW range
  function automatic longint round_sat(input longint x, output bit sat);
    longint d, y, q, omax, omin;
    d    = 64'sd1 <<< SH;
    y    = x + d / 2;
    q    = y / d;
    if ((y % d) != 0 && y < 0) q = q - 1;
    omax = (64'sd1 <<< (OW - 1)) - 1;
    omin = -(64'sd1 <<< (OW - 1));
    sat  = 1'b0;
    if (q > omax) begin q = omax; sat = 1'b1; end
    else if (q < omin) begin q = omin; sat = 1'b1; end
    return q;
  endfunction

  // Monitor and scoreboard: sampled on the falling edge, away from register updates
  always @(negedge ap_clk) begin
    longint prr, pii, pri, pir, re, im, rre, rim;
    bit     sre, sim, exp_rdy;
    exp_t   e;
    if (!ap_rst_n) begin
      exp_q.delete();
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      exp_rdy = !(occ == 2 && !m_ready);
      checks++;
      if (s_ready !== exp_rdy) begin
        errors++;
        $display("FAIL s_ready: got %b expected %b (occupancy %0d, m_ready %b)", s_ready, exp_rdy, occ, m_ready);
      end
      if (prev_stall) begin
        checks++;
        if ({m_valid, m_last, m_re, m_im} !== prev_out) begin
          errors++;
          $display("FAIL stall_hold: outputs %h changed from %h while stalled", {m_valid, m_last, m_re, m_im}, prev_out);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got beat re=%0d with nothing expected", $signed(m_re));
        end else begin
          e = exp_q.pop_front();
          if (m_re !== e.re || m_im !== e.im || m_last !== e.last) begin
            errors++;
            $display("FAIL beat_data: got re=%0d im=%0d last=%b expected re=%0d im=%0d last=%b",
                     $signed(m_re), $signed(m_im), m_last, $signed(e.re), $signed(e.im), e.last);
          end
          if (chk_lat) begin
            checks++;
            if (cyc - e.cyc != 2) begin
              errors++;
              $display("FAIL latency: got %0d cycles expected 2", cyc - e.cyc);
            end
          end
        end
        out_cnt++;
        occ--;
      end
      if (s_valid && s_ready === 1'b1) begin
        prr = $signed(s_p_rr);
        pii = $signed(s_p_ii);
        pri = $signed(s_p_ri);
        pir = $signed(s_p_ir);
        re  = (s_neg_r ? -prr : prr) - (s_neg_i ? -pii : pii);
        im  = (s_neg_i ? -pri : pri) + (s_neg_r ? -pir : pir);
        rre = round_sat(re, sre);
        rim = round_sat(im, sim);
        e.re   = rre[OW-1:0];
        e.im   = rim[OW-1:0];
        e.last = s_last;
        e.cyc  = cyc;
        exp_q.push_back(e);
        occ++;
        if (sre || sim) begin
          exp_sticky = 1'b1;
          if (exp_cnt < 65535) exp_cnt++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_last, m_re, m_im};
    end
  end

  task automatic set_in(input longint prr, pii, pri, pir, input bit nr, ni, lst);
    s_p_rr  = prr[PW-1:0];
    s_p_ii  = pii[PW-1:0];
    s_p_ri  = pri[PW-1:0];
    s_p_ir  = pir[PW-1:0];
    s_neg_r = nr;
    s_neg_i = ni;
    s_last  = lst;
  endtask

  // Holds s_valid until accepted; returns just after the transfer edge
  task automatic send(input longint prr, pii, pri, pir, input bit nr, ni, lst);
    bit acc;
    int guard;
    set_in(prr, pii, pri, pir, nr, ni, lst);
    s_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge ap_clk);
      acc = s_ready;
      @(posedge ap_clk); #1;
      if (acc) break;
      guard++;
      if (guard > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: s_ready stayed %b for 50 cycles, expected 1", s_ready);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || occ != 0) && guard < 60) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
    end
    @(posedge ap_clk); #1;
  endtask

  function automatic longint rand_p();
    logic [PW-1:0] r;
    longint v;
    r[31:0] = $urandom;
    r[32]   = 1'($urandom_range(0, 1));
    v = longint'($signed(r));
    if ($urandom_range(0, 1) == 1) v = v / 1024;
    return v;
  endfunction

  task automatic test_reset();
    int seen;
    ap_rst_n = 1'b0;
    m_ready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if ({m_valid, m_last, ovf_sticky} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/last/sticky=%b expected 000", {m_valid, m_last, ovf_sticky});
    end
    checks++;
    if (m_re !== '0 || m_im !== '0) begin
      errors++;
      $display("FAIL reset_data: got re=%h im=%h expected 0", m_re, m_im);
    end
    checks++;
    if (ovf_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", ovf_count);
    end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", s_ready);
    end
    @(posedge ap_clk); #1;
    m_ready = 1'b0;
    send(64'sd327680, 0, 0, 0, 0, 0, 0);
    send(64'sd655360, 0, 0, 0, 0, 0, 1);
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    m_ready  = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge ap_clk);
      if (m_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_flush: got %0d valid cycles after mid-stream reset expected 0", seen);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    send(64'sd32767000, 0, 0, 0, 0, 0, 0);
    @(negedge ap_clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: m_valid got %b one cycle after transfer, expected 0", m_valid);
    end
    @(negedge ap_clk);
    checks++;
    if (m_valid !== 1'b1 || m_re !== 18'd1000 || m_im !== 18'd0) begin
      errors++;
      $display("FAIL basic_pos: got valid=%b re=%0d im=%0d expected 1 1000 0", m_valid, $signed(m_re), $signed(m_im));
    end
    @(posedge ap_clk); #1;
    send(64'sd32767000, 0, 0, 0, 1, 0, 0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (m_valid !== 1'b1 || m_re !== -18'sd1000) begin
      errors++;
      $display("FAIL basic_neg: got valid=%b re=%0d expected 1 -1000", m_valid, $signed(m_re));
    end
    drain();
  endtask

  task automatic test_rounding();
    longint        pv[3];
    logic [OW-1:0] ev[3];
    pv[0] = 64'sd16384;  ev[0] = 18'd1;
    pv[1] = -64'sd16384; ev[1] = 18'd0;
    pv[2] = -64'sd16385; ev[2] = -18'sd1;
    for (int i = 0; i < 3; i++) begin
      send(pv[i], 0, 0, 0, 0, 0, 0);
      @(negedge ap_clk);
      @(negedge ap_clk);
      checks++;
      if (m_valid !== 1'b1 || m_re !== ev[i]) begin
        errors++;
        $display("FAIL round_%0d: p_rr=%0d got re=%0d expected %0d", i, pv[i], $signed(m_re), $signed(ev[i]));
      end
      @(posedge ap_clk); #1;
    end
    drain();
  endtask

  task automatic test_saturation();
    send(-64'sd4294836224, 64'sd4294803457, 0, 0, 1, 1, 0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (m_re !== 18'h1FFFF || m_im !== 18'd0) begin
      errors++;
      $display("FAIL sat_pos: got re=%0d im=%0d expected 131071 0", $signed(m_re), $signed(m_im));
    end
    checks++;
    if (ovf_sticky !== 1'b1 || ovf_count !== 16'd1) begin
      errors++;
      $display("FAIL sat_count1: got sticky=%b count=%0d expected 1 1", ovf_sticky, ovf_count);
    end
    @(posedge ap_clk); #1;
    send(64'sd4294836224, -64'sd4294803457, 0, 0, 1, 1, 0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (m_re !== 18'h20000) begin
      errors++;
      $display("FAIL sat_neg: got re=%0d expected -131072", $signed(m_re));
    end
    checks++;
    if (ovf_count !== 16'd2 || ovf_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL sat_count2: got %0d expected 2 (model %0d)", ovf_count, exp_cnt);
    end
    drain();
    ovf_clr = 1'b1;
    exp_cnt = 0;
    exp_sticky = 1'b0;
    @(posedge ap_clk); #1;
    ovf_clr = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (ovf_sticky !== 1'b0 || ovf_count !== '0) begin
      errors++;
      $display("FAIL sat_clear: got sticky=%b count=%0d expected 0 0", ovf_sticky, ovf_count);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_backpressure();
    int start_cnt;
    start_cnt = out_cnt;
    bp_on = 1'b1;
    fork
      while (bp_on) begin
        @(posedge ap_clk); #1;
        m_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      send(longint'(i + 1) * 98304, longint'(i) * 32768, longint'(i + 1) * 65536,
           longint'(i) * 16384, 0, 0, (i == 7));
    end
    bp_on = 1'b0;
    @(posedge ap_clk); #1;
    m_ready = 1'b1;
    drain();
    checks++;
    if (out_cnt - start_cnt != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d beats expected 8", out_cnt - start_cnt);
    end
  endtask

  task automatic test_throughput();
    int start_cnt;
    start_cnt = out_cnt;
    m_ready = 1'b1;
    chk_lat = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_in(rand_p(), rand_p(), rand_p(), rand_p(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), (i == 99));
      @(posedge ap_clk); #1;
    end
    s_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    checks++;
    if (out_cnt - start_cnt != 100) begin
      errors++;
      $display("FAIL tput_count: got %0d beats expected 100", out_cnt - start_cnt);
    end
    checks++;
    if (ovf_count !== 16'(exp_cnt) || ovf_sticky !== exp_sticky) begin
      errors++;
      $display("FAIL tput_ovf: got count=%0d sticky=%b expected %0d %b", ovf_count, ovf_sticky, exp_cnt, exp_sticky);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_throughput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
